// File: rtl/inv_park_transform.sv
// Inverse Park transform (d,q,theta -> alpha,beta) in Q1.15.
// One shared multiplier is stepped through four products by a small FSM.
module inv_park_transform (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] d,
  input  logic signed [15:0] q,
  input  logic        [15:0] theta,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [15:0] alpha,
  output logic signed [15:0] beta,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic [2:0] {IDLE, LUT, M0, M1, M2, M3, OUT} state_t;

  // Quarter-wave table: round(32767*sin(2*pi*i/256)) for i = 0..64.
  localparam logic signed [15:0] QSIN [0:64] = '{
    16'sd0,     16'sd804,   16'sd1608,  16'sd2410,  16'sd3212,  16'sd4011,  16'sd4808,  16'sd5602,
    16'sd6393,  16'sd7179,  16'sd7962,  16'sd8739,  16'sd9512,  16'sd10278, 16'sd11039, 16'sd11793,
    16'sd12539, 16'sd13279, 16'sd14010, 16'sd14732, 16'sd15446, 16'sd16151, 16'sd16846, 16'sd17530,
    16'sd18204, 16'sd18868, 16'sd19519, 16'sd20159, 16'sd20787, 16'sd21403, 16'sd22005, 16'sd22594,
    16'sd23170, 16'sd23731, 16'sd24279, 16'sd24811, 16'sd25329, 16'sd25832, 16'sd26319, 16'sd26790,
    16'sd27245, 16'sd27683, 16'sd28105, 16'sd28510, 16'sd28898, 16'sd29268, 16'sd29621, 16'sd29956,
    16'sd30273, 16'sd30571, 16'sd30852, 16'sd31113, 16'sd31356, 16'sd31580, 16'sd31785, 16'sd31971,
    16'sd32137, 16'sd32285, 16'sd32412, 16'sd32521, 16'sd32609, 16'sd32678, 16'sd32728, 16'sd32757,
    16'sd32767
  };

  function automatic logic signed [15:0] sin_lut(input logic [7:0] k);
    logic [6:0]         idx;
    logic signed [15:0] m;
    idx = k[6] ? (7'd64 - {1'b0, k[5:0]}) : {1'b0, k[5:0]};
    m   = QSIN[idx];
    return k[7] ? -m : m;
  endfunction

  // Round half up by adding 0.5 LSB before the arithmetic shift, then clamp.
  function automatic logic signed [15:0] round_sat(input logic signed [32:0] s);
    logic signed [33:0] t;
    logic signed [18:0] r;
    t = 34'(s) + 34'sd16384;
    r = 19'(t >>> 15);
    if (r > 19'sd32767)       return 16'sh7fff;
    else if (r < -19'sd32768) return 16'sh8000;
    else                      return r[15:0];
  endfunction

  state_t             state, state_next;
  logic signed [15:0] d_r, q_r, sin_r, cos_r, mul_a, mul_b;
  logic        [7:0]  k_r;
  logic signed [31:0] p_dcos, p_qsin, p_dsin, prod;
  logic signed [32:0] alpha_sum, beta_sum;

  // Angle bits below the table resolution are intentionally dropped.
  logic unused_theta_lsb;
  assign unused_theta_lsb = ^theta[7:0];

  // Handshake: a transfer happens on an edge where valid and ready are both 1.
  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = LUT;
      LUT:     state_next = M0;
      M0:      state_next = M1;
      M1:      state_next = M2;
      M2:      state_next = M3;
      M3:      state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      M0:      begin mul_a = d_r; mul_b = cos_r; end
      M1:      begin mul_a = q_r; mul_b = sin_r; end
      M2:      begin mul_a = d_r; mul_b = sin_r; end
      M3:      begin mul_a = q_r; mul_b = cos_r; end
      default: ;
    endcase
  end

  assign prod      = 32'(mul_a) * 32'(mul_b);
  assign alpha_sum = 33'(p_dcos) - 33'(p_qsin);
  // q*cos is consumed straight off the multiplier in M3.
  assign beta_sum  = 33'(p_dsin) + 33'(prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_r       <= '0;
      q_r       <= '0;
      k_r       <= '0;
      sin_r     <= '0;
      cos_r     <= '0;
      p_dcos    <= '0;
      p_qsin    <= '0;
      p_dsin    <= '0;
      alpha     <= '0;
      beta      <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          d_r <= d;
          q_r <= q;
          k_r <= theta[15:8];
        end
        LUT: begin
          sin_r <= sin_lut(k_r);
          cos_r <= sin_lut(k_r + 8'd64);
        end
        M0: p_dcos <= prod;
        M1: p_qsin <= prod;
        M2: p_dsin <= prod;
        M3: begin
          alpha     <= round_sat(alpha_sum);
          beta      <= round_sat(beta_sum);
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inv_park_transform.sv
// Directed bench for inv_park_transform: hand-computed vectors, latency,
// backpressure, mid-computation reset and back-to-back accept spacing.
module tb_inv_park_transform;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] d = '0;
  logic signed [15:0] q = '0;
  logic        [15:0] theta = '0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic               in_ready, out_valid;
  logic signed [15:0] alpha, beta;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic signed [15:0] dv;
    logic signed [15:0] qv;
    logic        [15:0] tv;
    logic signed [15:0] av;
    logic signed [15:0] bv;
  } vec_t;

  always #5 clk = ~clk;

  inv_park_transform dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .q         (q),
    .theta     (theta),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alpha     (alpha),
    .beta      (beta),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Drives one sample; lat counts edges from the accept edge (=1) to out_valid.
  task automatic send(input logic signed [15:0] dv, input logic signed [15:0] qv,
                      input logic [15:0] tv, output int lat);
    @(negedge clk);
    d = dv; q = qv; theta = tv; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    d     = 16'($urandom_range(0, 65535));
    q     = 16'($urandom_range(0, 65535));
    theta = 16'($urandom_range(0, 65535));
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (alpha !== 16'sd0) begin failures++; $display("FAIL reset_alpha got=%0d exp=0", alpha); end
    checks++; if (beta !== 16'sd0) begin failures++; $display("FAIL reset_beta got=%0d exp=0", beta); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_vectors();
    vec_t vecs[9];
    int   lat;
    vecs[0] = '{16'sd32767,  16'sd0,      16'h0000, 16'sd32767 - 16'sd1, 16'sd0};
    vecs[1] = '{16'sd32767,  16'sd0,      16'h4000, 16'sd0,      16'sd32766};
    vecs[2] = '{16'sd16384,  16'sd0,      16'h8000, -16'sd16383, 16'sd0};
    vecs[3] = '{16'sd32767,  -16'sd32768, 16'h2000, 16'sd32767,  -16'sd1};
    vecs[4] = '{-16'sd32768, 16'sd32767,  16'h2000, -16'sd32768, -16'sd1};
    vecs[5] = '{16'sd0,      16'sd16384,  16'h40ff, -16'sd16383, 16'sd0};
    vecs[6] = '{16'sd10000,  -16'sd5000,  16'h1000, 16'sd11152,  -16'sd793};
    vecs[7] = '{16'sd1000,   16'sd2000,   16'hc000, 16'sd2000,   -16'sd1000};
    vecs[8] = '{16'sd8192,   16'sd0,      16'h6000, -16'sd5792,  16'sd5793};
    for (int i = 0; i < 9; i++) begin
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL vec%0d in_ready_before got=%b exp=1", i, in_ready); end
      send(vecs[i].dv, vecs[i].qv, vecs[i].tv, lat);
      checks++; if (lat !== 6) begin failures++; $display("FAIL vec%0d latency got=%0d exp=6", i, lat); end
      checks++; if (alpha !== vecs[i].av) begin failures++; $display("FAIL vec%0d alpha got=%0d exp=%0d", i, alpha, vecs[i].av); end
      checks++; if (beta !== vecs[i].bv) begin failures++; $display("FAIL vec%0d beta got=%0d exp=%0d", i, beta, vecs[i].bv); end
      consume();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL vec%0d consumed_out_valid got=%b exp=0", i, out_valid); end
      checks++; if (alpha !== vecs[i].av) begin failures++; $display("FAIL vec%0d retained_alpha got=%0d exp=%0d", i, alpha, vecs[i].av); end
      checks++; if (beta !== vecs[i].bv) begin failures++; $display("FAIL vec%0d retained_beta got=%0d exp=%0d", i, beta, vecs[i].bv); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    send(16'sd10000, -16'sd5000, 16'h1000, lat);
    checks++; if (lat !== 6) begin failures++; $display("FAIL bp_latency got=%0d exp=6", lat); end
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      d = 16'($urandom_range(0, 65535));
      theta = 16'($urandom_range(0, 65535));
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid c=%0d got=%b exp=1", c, out_valid); end
      checks++; if (alpha !== 16'sd11152) begin failures++; $display("FAIL bp_hold_alpha c=%0d got=%0d exp=11152", c, alpha); end
      checks++; if (beta !== -16'sd793) begin failures++; $display("FAIL bp_hold_beta c=%0d got=%0d exp=-793", c, beta); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready c=%0d got=%b exp=0", c, in_ready); end
    end
    in_valid = 1'b0;
    consume();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
    checks++; if (alpha !== 16'sd11152) begin failures++; $display("FAIL bp_release_alpha got=%0d exp=11152", alpha); end
    repeat (8) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_ghost_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_idle_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    d = 16'sd32767; q = 16'sd0; theta = 16'h4000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (alpha !== 16'sd0) begin failures++; $display("FAIL midrst_alpha got=%0d exp=0", alpha); end
    checks++; if (beta !== 16'sd0) begin failures++; $display("FAIL midrst_beta got=%0d exp=0", beta); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_release_in_ready got=%b exp=1", in_ready); end
    send(16'sd32767, 16'sd0, 16'h0000, lat);
    checks++; if (lat !== 6) begin failures++; $display("FAIL midrst_latency got=%0d exp=6", lat); end
    checks++; if (alpha !== 16'sd32766) begin failures++; $display("FAIL midrst_alpha_after got=%0d exp=32766", alpha); end
    checks++; if (beta !== 16'sd0) begin failures++; $display("FAIL midrst_beta_after got=%0d exp=0", beta); end
    consume();
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int ov_cnt = 0;
    @(negedge clk);
    d = 16'sd1000; q = 16'sd2000; theta = 16'hc000;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (in_ready === 1'b1) acc.push_back(c);
      if (out_valid === 1'b1) begin
        ov_cnt++;
        checks++; if (alpha !== 16'sd2000) begin failures++; $display("FAIL b2b_alpha c=%0d got=%0d exp=2000", c, alpha); end
        checks++; if (beta !== -16'sd1000) begin failures++; $display("FAIL b2b_beta c=%0d got=%0d exp=-1000", c, beta); end
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (ov_cnt !== 2) begin failures++; $display("FAIL b2b_result_count got=%0d exp=2", ov_cnt); end
    checks++; if (acc.size() !== 3) begin failures++; $display("FAIL b2b_accept_count got=%0d exp=3", acc.size()); end
    if (acc.size() >= 3) begin
      checks++; if (acc[1] - acc[0] !== 7) begin failures++; $display("FAIL b2b_spacing1 got=%0d exp=7", acc[1] - acc[0]); end
      checks++; if (acc[2] - acc[1] !== 7) begin failures++; $display("FAIL b2b_spacing2 got=%0d exp=7", acc[2] - acc[1]); end
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inv_park_transform.md
INV_PARK_TRANSFORM -- requirements
Module: inv_park_transform

Interface
REQ-001 The block SHALL have no parameters; all data paths are fixed at 16-bit signed Q1.15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 d  input  16  signed Q1.15 direct-axis value.
REQ-005 q  input  16  signed Q1.15 quadrature-axis value.
REQ-006 theta  input  16  unsigned electrical angle; 0..65535 maps to 0..2π.
REQ-007 in_valid  input  1  d, q and theta are valid.
REQ-008 in_ready  output  1  block can accept a sample.
REQ-009 alpha  output  16  signed Q1.15 alpha-axis result.
REQ-010 beta  output  16  signed Q1.15 beta-axis result.
REQ-011 out_valid  output  1  alpha and beta are valid.
REQ-012 out_ready  input  1  downstream consumes the result.

Function
REQ-013 The block SHALL compute alpha = d·cos θ − q·sin θ and beta = d·sin θ + q·cos θ.
REQ-014 Angle index k SHALL be theta[15:8].
REQ-015 Internal table: sin(k) = round(32767·sin(2πk/256)); cos(k) = sin((k+64) mod 256).
REQ-016 The FSM SHALL have states IDLE, LUT, M0, M1, M2, M3, OUT.
REQ-017 in_ready SHALL be 1 only in IDLE and while rst is low; it is combinational from state.
REQ-018 Accept: an edge with in_valid=1 in IDLE SHALL capture d, q, theta and move to LUT; inputs after that edge SHALL be ignored until the next accept.
REQ-019 LUT SHALL register sin(k) and cos(k), then go to M0.
REQ-020 A single shared 16x16 signed multiplier SHALL compute d·cos (M0), q·sin (M1), d·sin (M2) and q·cos (M3), one product per state.
REQ-021 Products SHALL be 32-bit signed.
REQ-022 Sums and differences SHALL be formed at 33 bits with no intermediate overflow.
REQ-023 Each result SHALL be floor((sum + 16384) / 32768) using an arithmetic shift, i.e. round half up.
REQ-024 Each rounded result SHALL saturate to [−32768, 32767].
REQ-025 On the edge leaving M3, alpha and beta SHALL be registered and the FSM SHALL enter OUT with out_valid=1.
REQ-026 out_valid SHALL rise 6 edges after the accept edge.
REQ-027 In OUT, alpha, beta and out_valid SHALL hold stable until an edge with out_ready=1; that edge SHALL return the FSM to IDLE and clear out_valid.
REQ-028 A new sample SHALL NOT be accepted in the edge that consumes the output; minimum spacing between accepts is 7 cycles.
REQ-029 alpha and beta SHALL retain their last values after consumption, until the next result or reset.
REQ-030 in_valid while not in IDLE SHALL have no effect.
REQ-031 out_ready outside OUT SHALL have no effect.

Reset
REQ-032 On rst assertion, at any time including mid-computation, the block SHALL immediately force state=IDLE, alpha=0, beta=0, out_valid=0, in_ready=0, and clear all captured operands and partial products.
REQ-033 After rst deasserts, in_ready SHALL be 1 and the first accept SHALL behave as after power-up, with no residue from the aborted sample.

Verification
REQ-034 d=32767, q=0, theta=0x0000, out_ready=1 -> alpha=32766, beta=0; out_valid rises 6 edges after accept.
REQ-035 d=32767, q=0, theta=0x4000 -> alpha=0, beta=32766.
REQ-036 d=16384, q=0, theta=0x8000 (cos=−32767) -> alpha=−16383, beta=0, which checks rounding of a negative result.
REQ-037 d=32767, q=−32768, theta=0x2000 (sin=cos=23170) -> alpha saturates to 32767, beta=−1.
REQ-038 Backpressure: out_ready held 0 for 10 cycles after out_valid -> alpha, beta and out_valid stable; in_ready=0 throughout; in_valid pulses ignored; release -> out_valid clears after 1 edge and in_ready returns to 1.
REQ-039 Reset in M1 -> all outputs 0 immediately; the next sample d=32767, q=0, theta=0 yields alpha=32766 with normal latency.
